// File: rtl/byte_fifo_pkg.sv
// Shared constants and helpers for the byte FIFO slice.
package byte_fifo_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEFAULT_DEPTH = 8;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_fifo_if.sv
// Write/read/flag bundle between a FIFO and the logic that drives it.
interface byte_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, rd_data, rd_valid, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, rd_data, rd_valid, empty, count, overflow, underflow
  );

endinterface

// File: rtl/byte_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port.
module byte_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Array itself carries no reset so it stays a plain distributed RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO: pointers, occupancy counter, registered flags and error pulses.
module byte_fifo
  import byte_fifo_pkg::*;
#(
  parameter int DATA_W = BYTE_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      reset,
  byte_fifo_if.slave bus
);

  localparam int              CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_rd_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [DATA_W-1:0] w_rd_data;

  // A read frees a slot in the same cycle, so a write to a full FIFO is
  // accepted whenever a read accompanies it.
  always_comb begin
    w_wr_acc    = bus.wr_en & (~r_full | bus.rd_en);
    w_rd_acc    = bus.rd_en & ~r_empty;
    w_count_nxt = r_count;
    if (w_wr_acc & ~w_rd_acc)      w_count_nxt = r_count + 1'b1;
    else if (~w_wr_acc & w_rd_acc) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == LP_DEPTH);
      r_empty     <= (w_count_nxt == '0);
      r_rd_valid  <= w_rd_acc;
      r_overflow  <= bus.wr_en & r_full & ~bus.rd_en;
      r_underflow <= bus.rd_en & r_empty;
    end
  end

  byte_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (reset),
    .i_we    (w_wr_acc & ~reset),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.wr_data),
    .i_re    (w_rd_acc & ~reset),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  assign bus.rd_data   = w_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.full      = r_full;
  assign bus.empty     = r_empty;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

endmodule

// File: tb/tb_byte_fifo.sv
// Directed and random stimulus for byte_fifo, scored against a queue model every cycle.
module tb_byte_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic clk;
  logic reset;

  byte_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  byte_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_rd_data;
  logic              m_rd_valid;
  logic              m_overflow;
  logic              m_underflow;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: drive, advance model by the FIFO rules, compare every output.
  task automatic step(input logic rst, input logic we, input logic [DATA_W-1:0] wd,
                      input logic re, input string tag);
    bit was_full;
    bit was_empty;
    reset       = rst;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_rd_data   = '0;
      m_rd_valid  = 1'b0;
      m_overflow  = 1'b0;
      m_underflow = 1'b0;
    end else begin
      was_full    = (q.size() == DEPTH);
      was_empty   = (q.size() == 0);
      m_rd_valid  = 1'b0;
      m_overflow  = 1'b0;
      m_underflow = 1'b0;
      if (re && !was_empty) begin
        m_rd_data  = q.pop_front();
        m_rd_valid = 1'b1;
      end else if (re) begin
        m_underflow = 1'b1;
      end
      if (we && (!was_full || re)) q.push_back(wd);
      else if (we)                 m_overflow = 1'b1;
    end
    #1;
    chk({tag, ".count"},     32'(bus.count),     32'(q.size()));
    chk({tag, ".full"},      32'(bus.full),      32'(q.size() == DEPTH));
    chk({tag, ".empty"},     32'(bus.empty),     32'(q.size() == 0));
    chk({tag, ".rd_valid"},  32'(bus.rd_valid),  32'(m_rd_valid));
    chk({tag, ".rd_data"},   32'(bus.rd_data),   32'(m_rd_data));
    chk({tag, ".overflow"},  32'(bus.overflow),  32'(m_overflow));
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'(m_underflow));
  endtask

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;

    // 1: reset held with both requests active
    step(1, 1, 8'hFF, 1, "t1_rst");
    step(1, 1, 8'hEE, 1, "t1_rst");
    chk("t1_count0", 32'(bus.count), 32'd0);
    chk("t1_rd_data0", 32'(bus.rd_data), 32'd0);

    // 2: fill then drain in order
    for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h11 + i), 0, "t2_wr");
    chk("t2_full", 32'(bus.full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 8'h00, 1, "t2_rd");
      chk("t2_order", 32'(bus.rd_data), 32'(8'h11 + i));
    end
    chk("t2_empty", 32'(bus.empty), 32'd1);

    // 3: overflow on full
    for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h30 + i), 0, "t3_fill");
    step(0, 1, 8'hAA, 0, "t3_ovf");
    chk("t3_ovf_pulse", 32'(bus.overflow), 32'd1);
    step(0, 0, 8'h00, 1, "t3_rd");
    chk("t3_oldest", 32'(bus.rd_data), 32'h30);
    chk("t3_ovf_clear", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 7; i++) step(0, 0, 8'h00, 1, "t3_drain");

    // 4: simultaneous on empty
    step(0, 1, 8'h5C, 1, "t4_both");
    chk("t4_underflow", 32'(bus.underflow), 32'd1);
    chk("t4_count1", 32'(bus.count), 32'd1);
    step(0, 0, 8'h00, 1, "t4_rd");
    chk("t4_data", 32'(bus.rd_data), 32'h5C);

    // 5: sustained read+write while full, across pointer wraps
    for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h40 + i), 0, "t5_fill");
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 8'(8'h48 + i), 1, "t5_rw");
      chk("t5_stream", 32'(bus.rd_data), 32'(8'h40 + i));
    end
    for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 1, "t5_drain");

    // 6: reset in the middle of a read burst
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h60 + i), 0, "t6_wr");
    step(0, 0, 8'h00, 1, "t6_rd");
    step(0, 0, 8'h00, 1, "t6_rd");
    step(1, 1, 8'h99, 1, "t6_rst");
    chk("t6_rd_data0", 32'(bus.rd_data), 32'd0);
    step(0, 1, 8'h77, 0, "t6_new_wr");
    step(0, 0, 8'h00, 1, "t6_new_rd");
    chk("t6_new_data", 32'(bus.rd_data), 32'h77);
    step(0, 0, 8'h00, 1, "t6_under");

    // Random traffic, with rare resets
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom), 8'($urandom), 1'($urandom), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
